// File: rtl/fpu_inq_pkg.sv
// fpu_inq_pkg: shared definitions for the FPU input-queue scheduler.
//   - fpu_op_e        : target-pipe encoding carried on pcx_fpio_op
//   - DEF_DEPTH       : default number of inq_sram entries
//   - DEF_STALL_MARGIN: default free entries held back for in-flight packets
package fpu_inq_pkg;

  localparam int DEF_DEPTH        = 8;
  localparam int DEF_STALL_MARGIN = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_ILL = 2'b11
  } fpu_op_e;

endpackage

// File: rtl/fpu_inq_ptr.sv
// fpu_inq_ptr: wrapping queue pointer.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears ptr to 0
//   inc   - advance the pointer by one this cycle
//   ptr   - current pointer value, wraps DEPTH-1 -> 0
module fpu_inq_ptr #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/fpu_inq_sched.sv
// fpu_inq_sched: in-order scheduler for the FPU input queue (inq_sram).
// Incoming PCX packets are written into inq_sram at wptr; the head entry at
// rptr is dispatched to its add/mul/div pipe when that pipe is ready.
// Ports:
//   rclk, arst_l             - clock / async active-low reset
//   pcx_fpio_vld/op          - incoming packet valid and target pipe
//   add_rdy/mul_rdy/div_rdy  - pipe can accept an op this cycle
//   inq_we/inq_waddr         - inq_sram write port control
//   inq_re/inq_raddr         - inq_sram read port control (data next cycle)
//   add/mul/div_issue        - op dispatched to that pipe
//   inq_cnt/empty/full       - registered occupancy status
//   fpu_pcx_stall            - registered back-pressure to PCX
//   inq_err                  - sticky overflow / illegal-op flag
module fpu_inq_sched
  import fpu_inq_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STALL_MARGIN = DEF_STALL_MARGIN
) (
  input  logic                     rclk,
  input  logic                     arst_l,
  input  logic                     pcx_fpio_vld,
  input  logic [1:0]               pcx_fpio_op,
  input  logic                     add_rdy,
  input  logic                     mul_rdy,
  input  logic                     div_rdy,
  output logic                     inq_we,
  output logic [$clog2(DEPTH)-1:0] inq_waddr,
  output logic                     inq_re,
  output logic [$clog2(DEPTH)-1:0] inq_raddr,
  output logic                     add_issue,
  output logic                     mul_issue,
  output logic                     div_issue,
  output logic [$clog2(DEPTH):0]   inq_cnt,
  output logic                     inq_empty,
  output logic                     inq_full,
  output logic                     fpu_pcx_stall,
  output logic                     inq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] STALL_TH = (AW + 1)'(DEPTH - STALL_MARGIN);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_next;
  logic          legal;
  logic          we_int;
  logic          re_int;
  logic          head_rdy;
  fpu_op_e       head_op;
  fpu_op_e       op_file [DEPTH];

  fpu_inq_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (rclk),
    .rst_n (arst_l),
    .inc   (we_int),
    .ptr   (wptr)
  );

  fpu_inq_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (rclk),
    .rst_n (arst_l),
    .inc   (re_int),
    .ptr   (rptr)
  );

  // Full/empty come from the registered count, so an entry written this
  // cycle cannot be issued, and a slot freed this cycle cannot be refilled.
  assign inq_cnt   = cnt;
  assign inq_empty = (cnt == '0);
  assign inq_full  = (cnt == FULL_CNT);

  always_comb begin
    legal   = (pcx_fpio_op != OP_ILL);
    head_op = op_file[rptr];
    case (head_op)
      OP_ADD:  head_rdy = add_rdy;
      OP_MUL:  head_rdy = mul_rdy;
      OP_DIV:  head_rdy = div_rdy;
      default: head_rdy = 1'b0;
    endcase
    we_int   = pcx_fpio_vld & legal & ~inq_full;
    re_int   = ~inq_empty & head_rdy;
    cnt_next = cnt + (AW + 1)'(we_int) - (AW + 1)'(re_int);
  end

  // Reset only masks the outward write strobe; the pointers are already held
  // in reset, and the read side is quiet because the count is zero.
  assign inq_we    = we_int & arst_l;
  assign inq_waddr = wptr;
  assign inq_re    = re_int;
  assign inq_raddr = rptr;
  assign add_issue = re_int & (head_op == OP_ADD);
  assign mul_issue = re_int & (head_op == OP_MUL);
  assign div_issue = re_int & (head_op == OP_DIV);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      cnt           <= '0;
      fpu_pcx_stall <= 1'b0;
      inq_err       <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      fpu_pcx_stall <= (cnt_next >= STALL_TH);
      if (pcx_fpio_vld & (~legal | inq_full)) begin
        inq_err <= 1'b1;
      end
    end
  end

  // Op file holds only the pipe selector; contents are don't-care until written.
  always_ff @(posedge rclk) begin
    if (we_int) begin
      op_file[wptr] <= fpu_op_e'(pcx_fpio_op);
    end
  end

endmodule

// File: tb/tb_fpu_inq_sched.sv
// tb_fpu_inq_sched: scoreboard bench for fpu_inq_sched.
// The driver advances a queue-based reference model each cycle and pushes
// expected writes/issues (tagged with their cycle); a monitor at the falling
// edge pops and compares whenever the DUT asserts inq_we or inq_re.
module tb_fpu_inq_sched;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;
  localparam int AW     = 3;

  logic          rclk = 1'b0;
  logic          arst_l;
  logic          pcx_fpio_vld;
  logic [1:0]    pcx_fpio_op;
  logic          add_rdy, mul_rdy, div_rdy;
  logic          inq_we, inq_re;
  logic [AW-1:0] inq_waddr, inq_raddr;
  logic          add_issue, mul_issue, div_issue;
  logic [AW:0]   inq_cnt;
  logic          inq_empty, inq_full, fpu_pcx_stall, inq_err;

  fpu_inq_sched #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .rclk          (rclk),
    .arst_l        (arst_l),
    .pcx_fpio_vld  (pcx_fpio_vld),
    .pcx_fpio_op   (pcx_fpio_op),
    .add_rdy       (add_rdy),
    .mul_rdy       (mul_rdy),
    .div_rdy       (div_rdy),
    .inq_we        (inq_we),
    .inq_waddr     (inq_waddr),
    .inq_re        (inq_re),
    .inq_raddr     (inq_raddr),
    .add_issue     (add_issue),
    .mul_issue     (mul_issue),
    .div_issue     (div_issue),
    .inq_cnt       (inq_cnt),
    .inq_empty     (inq_empty),
    .inq_full      (inq_full),
    .fpu_pcx_stall (fpu_pcx_stall),
    .inq_err       (inq_err)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    int cyc;
    int op;
    int addr;
  } exp_t;

  exp_t wr_q[$];
  exp_t is_q[$];
  int   model_q[$];     // ops currently held, oldest first
  int   wp, rp;
  bit   m_err, m_stall;
  int   cyc;
  int   exp_cnt;
  bit   exp_err, exp_stall;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle of stimulus; the model sees the state at cycle start.
  task automatic step(input bit v, input int op, input bit ar, input bit mr, input bit dr);
    bit full, empty;
    bit rdy [3];
    int hop;
    @(posedge rclk);
    #1;
    pcx_fpio_vld = v;
    pcx_fpio_op  = 2'(op);
    add_rdy      = ar;
    mul_rdy      = mr;
    div_rdy      = dr;
    cyc++;
    exp_cnt   = model_q.size();
    exp_err   = m_err;
    exp_stall = m_stall;
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    rdy[0] = ar;
    rdy[1] = mr;
    rdy[2] = dr;
    if (!empty) begin
      hop = model_q[0];
      if (rdy[hop]) begin
        is_q.push_back('{cyc: cyc, op: hop, addr: rp});
        void'(model_q.pop_front());
        rp = (rp + 1) % DEPTH;
      end
    end
    if (v && op != 3 && !full) begin
      wr_q.push_back('{cyc: cyc, op: op, addr: wp});
      model_q.push_back(op);
      wp = (wp + 1) % DEPTH;
    end
    if (v && (op == 3 || full)) m_err = 1'b1;
    m_stall = (model_q.size() >= DEPTH - MARGIN);
  endtask

  task automatic idle(input int n, input bit ar, input bit mr, input bit dr);
    for (int i = 0; i < n; i++) step(1'b0, 0, ar, mr, dr);
  endtask

  // Assert reset mid-cycle with live inputs and check the async clear.
  task automatic do_reset();
    @(negedge rclk);
    #2;
    arst_l       = 1'b0;
    pcx_fpio_vld = 1'b1;
    pcx_fpio_op  = 2'b00;
    add_rdy      = 1'b1;
    mul_rdy      = 1'b1;
    div_rdy      = 1'b1;
    #1;
    check("rst_cnt",   32'(inq_cnt), 0);
    check("rst_empty", 32'(inq_empty), 1);
    check("rst_full",  32'(inq_full), 0);
    check("rst_err",   32'(inq_err), 0);
    check("rst_stall", 32'(fpu_pcx_stall), 0);
    check("rst_we",    32'(inq_we), 0);
    check("rst_re",    32'(inq_re), 0);
    check("rst_issue", 32'({add_issue, mul_issue, div_issue}), 0);
    check("rst_pending", 32'(wr_q.size() + is_q.size()), 0);
    model_q.delete();
    wp = 0; rp = 0; m_err = 1'b0; m_stall = 1'b0;
    exp_cnt = 0; exp_err = 1'b0; exp_stall = 1'b0;
    repeat (2) @(negedge rclk);
    #2;
    pcx_fpio_vld = 1'b0;
    arst_l       = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT drives a write or an issue.
  always @(negedge rclk) begin
    exp_t e;
    int   act_op;
    if (inq_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("we_spurious", 1, 0);
      end else begin
        e = wr_q.pop_front();
        check("we_cycle", 32'(cyc), 32'(e.cyc));
        check("waddr", 32'(inq_waddr), 32'(e.addr));
      end
    end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
      e = wr_q.pop_front();
      check("we_missing", 0, 1);
    end
    if (inq_re === 1'b1) begin
      check("issue_onehot", 32'($countones({add_issue, mul_issue, div_issue})), 1);
      act_op = add_issue ? 0 : mul_issue ? 1 : div_issue ? 2 : 3;
      if (is_q.size() == 0) begin
        check("issue_spurious", 1, 0);
      end else begin
        e = is_q.pop_front();
        check("issue_cycle", 32'(cyc), 32'(e.cyc));
        check("issue_pipe", 32'(act_op), 32'(e.op));
        check("raddr", 32'(inq_raddr), 32'(e.addr));
      end
    end else begin
      check("issue_without_re", 32'({add_issue, mul_issue, div_issue}), 0);
      if (is_q.size() > 0 && is_q[0].cyc <= cyc) begin
        e = is_q.pop_front();
        check("issue_missing", 0, 1);
      end
    end
    check("cnt",   32'(inq_cnt), 32'(exp_cnt));
    check("empty", 32'(inq_empty), 32'(exp_cnt == 0));
    check("full",  32'(inq_full), 32'(exp_cnt == DEPTH));
    check("err",   32'(inq_err), 32'(exp_err));
    check("stall", 32'(fpu_pcx_stall), 32'(exp_stall));
  end

  initial begin
    arst_l = 1'b0;
    pcx_fpio_vld = 1'b0; pcx_fpio_op = 2'b00;
    add_rdy = 1'b0; mul_rdy = 1'b0; div_rdy = 1'b0;
    cyc = 0; wp = 0; rp = 0; m_err = 1'b0; m_stall = 1'b0;
    exp_cnt = 0; exp_err = 1'b0; exp_stall = 1'b0;
    do_reset();

    // Single add: write in cycle 1, issue in cycle 2.
    step(1'b1, 0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b0, 1'b0);

    // Fill to full with every pipe blocked, then one dropped packet.
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b1, 1'b1, 1'b1);  // full at cycle start: dropped even though issuing
    idle(DEPTH + 2, 1'b1, 1'b1, 1'b1);

    // Head-of-line blocking: [div, add] with only add ready.
    do_reset();
    step(1'b1, 2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 0, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1, 1'b1, 1'b1);

    // Steady state at cnt=3 with concurrent write and issue, wrapping pointers.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, $urandom_range(0, 2), 1'b1, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1, 1'b1);

    // Illegal op: no write, sticky error until reset.
    step(1'b1, 3, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1, 1'b1);

    // Reset with five entries queued; nothing issues afterwards.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(4, 1'b1, 1'b1, 1'b1);

    // Randomised traffic with an occasional illegal op and a mid-run reset.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 3) != 0,
             ($urandom_range(0, 29) == 0) ? 3 : $urandom_range(0, 2),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      do_reset();
    end
    idle(DEPTH + 2, 1'b1, 1'b1, 1'b1);

    @(negedge rclk);
    #1;
    check("leftover_expectations", 32'(wr_q.size() + is_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_inq_sched.md
FPU_INQ_SCHED -- requirements
Module: fpu_inq_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of inq_sram entries managed (power of two, 4..16).
REQ-002 SHALL have parameter STALL_MARGIN, default 2, free entries reserved to absorb in-flight PCX packets.
REQ-003 SHALL have port rclk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port arst_l  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pcx_fpio_vld  input  1  incoming FP packet valid, one entry per cycle.
REQ-006 SHALL have port pcx_fpio_op  input  2  target pipe: 00 add, 01 mul, 10 div, 11 illegal.
REQ-007 SHALL have port add_rdy / mul_rdy / div_rdy  input  1 each  pipe can accept an op this cycle.
REQ-008 SHALL have port inq_we  output  1  inq_sram write enable.
REQ-009 SHALL have port inq_waddr  output  log2(DEPTH)  inq_sram write address.
REQ-010 SHALL have port inq_re  output  1  inq_sram read enable.
REQ-011 SHALL have port inq_raddr  output  log2(DEPTH)  inq_sram read address.
REQ-012 SHALL have port add_issue / mul_issue / div_issue  output  1 each  op dispatched to that pipe; data valid from sram next cycle.
REQ-013 SHALL have port inq_cnt  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have ports inq_empty, inq_full  output  1 each  occupancy == 0 / == DEPTH.
REQ-015 SHALL have port fpu_pcx_stall  output  1  back-pressure to PCX.
REQ-016 SHALL have port inq_err  output  1  sticky overflow/illegal-op flag.

Function
REQ-017 Write: pcx_fpio_vld & legal op & !inq_full SHALL assert inq_we combinationally, inq_waddr = wptr; wptr advances, op code stored in per-entry op file at wptr.
REQ-018 Illegal op (11) with vld SHALL not write, not advance wptr, and set inq_err.
REQ-019 vld while inq_full SHALL drop the packet (no inq_we) and set inq_err.
REQ-020 Issue: strictly in order; head op = op file[rptr]; issue when !inq_empty and head pipe rdy; exactly one of *_issue asserted with inq_re, inq_raddr = rptr; rptr advances.
REQ-021 Head blocked by its pipe's rdy SHALL stall all younger entries (no reordering).
REQ-022 No write-to-issue bypass: entry written in cycle N is issuable no earlier than N+1 (inq_empty registered-state based).
REQ-023 Simultaneous write and issue SHALL leave inq_cnt unchanged; write allowed when full only if not full at cycle start (no same-cycle freeing).
REQ-024 Pointers SHALL wrap modulo DEPTH; full/empty derived from inq_cnt, not pointer compare.
REQ-025 fpu_pcx_stall SHALL be registered, = (next inq_cnt >= DEPTH - STALL_MARGIN).
REQ-026 inq_cnt, inq_empty, inq_full SHALL reflect registered state (update cycle after event).
REQ-027 inq_we/inq_re/*_issue SHALL be combinational from registered state and current-cycle inputs; read latency 1 cycle.

Reset
REQ-028 arst_l low SHALL asynchronously clear wptr, rptr, inq_cnt=0, inq_err=0, fpu_pcx_stall=0; inq_empty=1, inq_full=0.
REQ-029 During reset inq_we, inq_re, all *_issue SHALL be 0; op file contents need not reset.
REQ-030 Reset mid-operation SHALL discard all queued entries; no issue until first post-reset write.

Structure
REQ-031 Shared package fpu_inq_pkg SHALL hold op encodings (OP_ADD, OP_MUL, OP_DIV, OP_ILL) and default DEPTH/STALL_MARGIN.
REQ-032 One sub-module fpu_inq_ptr SHALL implement a wrapping pointer with increment enable and async reset, instantiated for wptr and rptr.

Verification
REQ-033 Reset, then vld op=00 at cycle 1 with add_rdy=1 -> inq_we, waddr=0 cycle 1; add_issue, inq_re, raddr=0 cycle 2; cnt 1 then 0.
REQ-034 Fill 8 writes with all rdy=0 -> inq_full=1, cnt=8, fpu_pcx_stall=1 after 6th write; 9th vld dropped, inq_err=1.
REQ-035 Queue [div, add], div_rdy=0, add_rdy=1 for 5 cycles -> no issue; div_rdy=1 -> div_issue then add_issue next cycle.
REQ-036 cnt=3, simultaneous vld and issue each cycle for 20 cycles -> cnt stays 3, pointers wrap past 7 to 0 correctly.
REQ-037 vld with op=11 -> no inq_we, wptr unchanged, inq_err=1 until arst_l pulse.
REQ-038 arst_l asserted mid-stream with cnt=5 -> outputs cleared immediately, cnt=0, empty=1, no issue after release.
